// File: rtl/matrix_div_sequencer.sv
// matrix_div_sequencer: divides a captured 3x3 matrix of 4-bit elements by a
// 4-bit scalar, one element at a time, through a shared start/done divider.
// Ports: clk, reset (sync, active-high); start, mat_in, scalar request a run;
// div_start/div_dividend/div_divisor drive the divider and div_done/div_quotient
// return its result; result holds the nine quotients; busy/done/div_by_zero
// report progress.
module matrix_div_sequencer #(
    parameter int NUM_ELEM = 9,
    parameter int ELEM_W   = 4,
    parameter int DIV_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_ELEM*ELEM_W-1:0]   mat_in,
    input  logic [ELEM_W-1:0]            scalar,
    output logic                         div_start,
    output logic [DIV_W-1:0]             div_dividend,
    output logic [DIV_W-1:0]             div_divisor,
    input  logic                         div_done,
    input  logic [DIV_W-1:0]             div_quotient,
    output logic [NUM_ELEM*DIV_W-1:0]    result,
    output logic                         busy,
    output logic                         done,
    output logic                         div_by_zero
);

    localparam int IDX_W = $clog2(NUM_ELEM);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [ELEM_W-1:0]   elem_q [NUM_ELEM];
    logic [ELEM_W-1:0]   scalar_q;
    logic [DIV_W-1:0]    res_q [NUM_ELEM];
    logic                dbz_q;
    logic                active;

    // Divider operands come only from captured registers and the state, so
    // they stay stable across WAIT and read zero outside a sequence.
    assign active       = (state == ISSUE) || (state == WAIT);
    assign div_start    = (state == ISSUE);
    assign busy         = active;
    assign done         = (state == FINISH);
    assign div_by_zero  = dbz_q;
    assign div_dividend = active ? {{(DIV_W-ELEM_W){1'b0}}, elem_q[idx]} : '0;
    assign div_divisor  = active ? {{(DIV_W-ELEM_W){1'b0}}, scalar_q} : '0;

    always_comb begin
        result = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            result[k*DIV_W +: DIV_W] = res_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            scalar_q <= '0;
            dbz_q    <= 1'b0;
            for (int k = 0; k < NUM_ELEM; k++) begin
                elem_q[k] <= '0;
                res_q[k]  <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NUM_ELEM; k++) begin
                            elem_q[k] <= mat_in[k*ELEM_W +: ELEM_W];
                            res_q[k]  <= '0;
                        end
                        scalar_q <= scalar;
                        idx      <= '0;
                        // A zero divisor skips the divider entirely.
                        if (scalar == '0) begin
                            dbz_q <= 1'b1;
                            state <= FINISH;
                        end else begin
                            dbz_q <= 1'b0;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (div_done) begin
                        res_q[idx] <= div_quotient;
                        if (idx == IDX_W'(NUM_ELEM - 1)) begin
                            state <= FINISH;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ISSUE;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
